mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline latch. Takes the latched EX results and performs the
//  data-memory access over a req/ack handshake. Stalls the upstream pipeline while memory is busy.
//  Selects the writeback value and registers it as the MEM/WB latch feeding the register file.
// PARAMETERS
//  DATA_BIT_WIDTH  32  width of data, address and PC values
//  RESET_VALUE     0   reset value of every registered output
//  MEM_TIMEOUT     15  max wait cycles for memAck before aborting (4-bit counter, 1..15)
// PORTS
//  clk              in   1   single clock, all state on posedge
//  reset            in   1   synchronous, active-high
//  pcIncrementedIn  in   32  EX/MEM latch: PC+4
//  aluResultIn      in   32  EX/MEM latch: ALU result / memory address
//  condRegResultIn  in   32  EX/MEM latch: compare result
//  regData2In       in   32  EX/MEM latch: store data
//  regWriteNoIn     in   4   EX/MEM latch: destination register
//  wrMemIn          in   1   EX/MEM latch: store
//  wrRegIn          in   1   EX/MEM latch: register write enable
//  dstRegMuxSelIn   in   2   wb select: 0 ALU, 1 MEM (load), 2 PC+4, 3 COND
//  memReq           out  1   data-memory request
//  memWe            out  1   1 store, 0 load (valid with memReq)
//  memAddr          out  32  byte address
//  memWdata         out  32  store data
//  memRdata         in   32  load data, valid when memAck
//  memAck           in   1   request complete
//  stall            out  1   hold PC, IF/ID, ID/EX and EX/MEM latches
//  memErr           out  1   sticky timeout flag
//  wbData           out  32  MEM/WB latch: writeback value
//  wbRegNo          out  4   MEM/WB latch: destination register
//  wbWrReg          out  1   MEM/WB latch: register write strobe
// BEHAVIOUR
//  - memOp = wrMemIn | (dstRegMuxSelIn==1). isLoad = dstRegMuxSelIn==1 & ~wrMemIn.
//  - FSM IDLE, WAIT. Reset: state IDLE, wait counter 0, memErr 0. All wb* outputs go to RESET_VALUE.
//  - IDLE, ~memOp: memReq=0, stall=0. Next edge: wbData=mux(sel), wbRegNo/wbWrReg from inputs.
//    Latency is 1 cycle.
//  - IDLE, memOp: memReq=1 combinationally. memAddr=aluResultIn, memWdata=regData2In, memWe=wrMemIn.
//    If memAck in the same cycle: stall=0 and the op retires on this edge.
//    A load retires with wbData=memRdata.
//    Else: stall=1. The request is captured into addr/wdata/we/regNo/wrReg/isLoad registers,
//    the counter loads 1, and the FSM goes to WAIT.
//  - WAIT: memReq=1. memAddr/memWdata/memWe come from captured registers, not inputs.
//    While memAck=0 and counter<MEM_TIMEOUT: stall=1 and wbWrReg=0 (bubble); counter increments.
//    memAck=1: stall=0, retire the captured op (load data=memRdata), go to IDLE.
//    Timeout (counter==MEM_TIMEOUT, no ack): memErr<=1, retire with wbData=0 and wbWrReg=0.
//    Go to IDLE with stall=0 that cycle.
//  - Store retires with wbWrReg=wrRegIn&~wrMemIn (normally 0). A store never writes memRdata.
//  - memAck while IDLE with ~memOp is ignored. memAck arriving after a timeout is ignored.
//  - memErr clears only on reset.
//  - Reset mid-WAIT: memReq drops the next cycle. Captured request is discarded; no retirement.
//  - Next op is accepted in the cycle after retirement. There are no back-to-back issues from WAIT.
// STRUCTURE
//  - Shared pkg/include: WB_SEL_ALU=0, WB_SEL_MEM=1, WB_SEL_PC=2, WB_SEL_COND=3.
//    Also FSM state encodings ST_IDLE=0, ST_WAIT=1.
//  - One sub-module: mem_wb_latch (registers wbData/wbRegNo/wbWrReg with reset). FSM and mux stay local.
// TESTING
//  1 ALU op: aluResultIn=0x1234, sel=0, wrReg=1, reg=5 -> next edge wbData=0x1234, wbRegNo=5,
//    wbWrReg=1, memReq=0, stall=0.
//  2 Zero-wait load: sel=1, addr=0x40, memAck same cycle, memRdata=0xDEADBEEF -> stall=0;
//    next edge wbData=0xDEADBEEF.
//  3 3-wait store: wrMem=1, addr=0x80, data=0xA5A5A5A5, ack on cycle 4 -> stall high 3 cycles.
//    memAddr/memWdata stay stable in WAIT; wbWrReg=0 throughout.
//  4 Timeout: load, memAck never -> stall for 15 cycles, then memErr=1, wbWrReg=0, FSM IDLE.
//    A late ack is ignored.
//  5 Reset mid-WAIT: load issued, reset on wait cycle 2 -> next cycle memReq=0, stall=0,
//    wb* = 0, memErr=0.
//  6 PC/COND select: sel=2, PC+4=0x104 -> wbData=0x104. Then sel=3, cond=1 -> wbData=1
//    (back-to-back, no stall).

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: writeback select codes and FSM states.
package mem_access_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_PC   = 2'd2;
  localparam logic [1:0] WB_SEL_COND = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline latch: registers the writeback value, destination and write strobe.
module mem_wb_latch #(
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_BIT_WIDTH-1:0] dataIn,
  input  logic [3:0]                regNoIn,
  input  logic                      wrRegIn,
  output logic [DATA_BIT_WIDTH-1:0] wbData,
  output logic [3:0]                wbRegNo,
  output logic                      wbWrReg
);

  // Stage boundary MEM -> WB: every field returns to RESET_VALUE on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbData  <= RESET_VALUE;
      wbRegNo <= RESET_VALUE[3:0];
      wbWrReg <= RESET_VALUE[0];
    end else begin
      wbData  <= dataIn;
      wbRegNo <= regNoIn;
      wbWrReg <= wrRegIn;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues data-memory requests over req/ack, stalls upstream while
// the memory is busy, aborts after a bounded wait and feeds the MEM/WB latch.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE    = '0,
  parameter int                        MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_BIT_WIDTH-1:0] pcIncrementedIn,
  input  logic [DATA_BIT_WIDTH-1:0] aluResultIn,
  input  logic [DATA_BIT_WIDTH-1:0] condRegResultIn,
  input  logic [DATA_BIT_WIDTH-1:0] regData2In,
  input  logic [3:0]                regWriteNoIn,
  input  logic                      wrMemIn,
  input  logic                      wrRegIn,
  input  logic [1:0]                dstRegMuxSelIn,
  output logic                      memReq,
  output logic                      memWe,
  output logic [DATA_BIT_WIDTH-1:0] memAddr,
  output logic [DATA_BIT_WIDTH-1:0] memWdata,
  input  logic [DATA_BIT_WIDTH-1:0] memRdata,
  input  logic                      memAck,
  output logic                      stall,
  output logic                      memErr,
  output logic [DATA_BIT_WIDTH-1:0] wbData,
  output logic [3:0]                wbRegNo,
  output logic                      wbWrReg
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

  // Writeback mux; a store routed through the MEM code falls back to the ALU value.
  function automatic logic [DATA_BIT_WIDTH-1:0] selectWb(
    input logic [1:0]                sel,
    input logic [DATA_BIT_WIDTH-1:0] alu,
    input logic [DATA_BIT_WIDTH-1:0] memVal,
    input logic [DATA_BIT_WIDTH-1:0] pc,
    input logic [DATA_BIT_WIDTH-1:0] cond
  );
    case (sel)
      WB_SEL_MEM: selectWb = memVal;
      WB_SEL_PC:  selectWb = pc;
      WB_SEL_COND: selectWb = cond;
      default:    selectWb = alu;
    endcase
  endfunction

  memState_t state, nextState;
  logic [3:0] waitCnt;
  logic       memOp, isLoad, timeoutHit, issueWait;

  // Request captured when memory does not answer in the issue cycle.
  logic [DATA_BIT_WIDTH-1:0] capAddr_p1, capWdata_p1;
  logic                      capWe_p1, capWrReg_p1, capIsLoad_p1;
  logic [3:0]                capRegNo_p1;

  logic [DATA_BIT_WIDTH-1:0] latchData, memValue;
  logic [3:0]                latchRegNo;
  logic                      latchWrReg;

  assign memOp      = wrMemIn | (dstRegMuxSelIn == WB_SEL_MEM);
  assign isLoad     = (dstRegMuxSelIn == WB_SEL_MEM) & ~wrMemIn;
  assign memValue   = isLoad ? memRdata : aluResultIn;
  assign issueWait  = (state == ST_IDLE) & memOp & ~memAck;
  assign timeoutHit = (state == ST_WAIT) & ~memAck & (waitCnt == TIMEOUT_CNT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state: enter WAIT on an unanswered issue, leave on ack or timeout.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (memOp && !memAck) nextState = ST_WAIT;
      ST_WAIT: if (memAck || timeoutHit) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs: memory port, stall and the value presented to the MEM/WB latch.
  always_comb begin
    memReq     = 1'b0;
    memWe      = wrMemIn;
    memAddr    = aluResultIn;
    memWdata   = regData2In;
    stall      = 1'b0;
    latchData  = selectWb(dstRegMuxSelIn, aluResultIn, memValue, pcIncrementedIn, condRegResultIn);
    latchRegNo = regWriteNoIn;
    latchWrReg = wrRegIn & ~wrMemIn;
    case (state)
      ST_IDLE: begin
        if (memOp) begin
          memReq = 1'b1;
          if (!memAck) begin
            stall      = 1'b1;
            latchWrReg = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        memReq     = 1'b1;
        memWe      = capWe_p1;
        memAddr    = capAddr_p1;
        memWdata   = capWdata_p1;
        latchRegNo = capRegNo_p1;
        latchData  = capIsLoad_p1 ? memRdata : capAddr_p1;
        latchWrReg = capWrReg_p1;
        if (!memAck) begin
          latchWrReg = 1'b0;
          if (timeoutHit) latchData = '0;
          else            stall     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= 4'd0;
      memErr  <= 1'b0;
    end else begin
      if (issueWait)
        waitCnt <= 4'd1;
      else if (state == ST_WAIT && !memAck && !timeoutHit)
        waitCnt <= waitCnt + 4'd1;
      else
        waitCnt <= 4'd0;
      if (timeoutHit) memErr <= 1'b1;
    end
  end

  // Stage boundary issue -> WAIT: hold the request so memory sees stable values.
  always_ff @(posedge clk) begin
    if (issueWait) begin
      capAddr_p1   <= aluResultIn;
      capWdata_p1  <= regData2In;
      capWe_p1     <= wrMemIn;
      capRegNo_p1  <= regWriteNoIn;
      capWrReg_p1  <= wrRegIn & ~wrMemIn;
      capIsLoad_p1 <= isLoad;
    end
  end

  mem_wb_latch #(
    .DATA_BIT_WIDTH(DATA_BIT_WIDTH),
    .RESET_VALUE   (RESET_VALUE)
  ) u_memWbLatch (
    .clk    (clk),
    .reset  (reset),
    .dataIn (latchData),
    .regNoIn(latchRegNo),
    .wrRegIn(latchWrReg),
    .wbData (wbData),
    .wbRegNo(wbRegNo),
    .wbWrReg(wbWrReg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU, loads, stores with waits, timeout, reset, selects.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIncrementedIn, aluResultIn, condRegResultIn, regData2In;
  logic [3:0]  regWriteNoIn;
  logic        wrMemIn, wrRegIn;
  logic [1:0]  dstRegMuxSelIn;
  logic        memReq, memWe, memAck, stall, memErr, wbWrReg;
  logic [31:0] memAddr, memWdata, memRdata, wbData;
  logic [3:0]  wbRegNo;

  int numChecks = 0;
  int numFails  = 0;
  int stallCount;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_BIT_WIDTH(32),
    .RESET_VALUE   (32'd0),
    .MEM_TIMEOUT   (15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pcIncrementedIn(pcIncrementedIn),
    .aluResultIn    (aluResultIn),
    .condRegResultIn(condRegResultIn),
    .regData2In     (regData2In),
    .regWriteNoIn   (regWriteNoIn),
    .wrMemIn        (wrMemIn),
    .wrRegIn        (wrRegIn),
    .dstRegMuxSelIn (dstRegMuxSelIn),
    .memReq         (memReq),
    .memWe          (memWe),
    .memAddr        (memAddr),
    .memWdata       (memWdata),
    .memRdata       (memRdata),
    .memAck         (memAck),
    .stall          (stall),
    .memErr         (memErr),
    .wbData         (wbData),
    .wbRegNo        (wbRegNo),
    .wbWrReg        (wbWrReg)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    pcIncrementedIn = 32'd0;
    aluResultIn     = 32'd0;
    condRegResultIn = 32'd0;
    regData2In      = 32'd0;
    regWriteNoIn    = 4'd0;
    wrMemIn         = 1'b0;
    wrRegIn         = 1'b0;
    dstRegMuxSelIn  = 2'd0;
    memAck          = 1'b0;
    memRdata        = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    checkVal("rst_wbData", wbData, 32'd0);
    checkVal("rst_wbRegNo", 32'(wbRegNo), 32'd0);
    checkVal("rst_wbWrReg", 32'(wbWrReg), 32'd0);
    checkVal("rst_memErr", 32'(memErr), 32'd0);
    checkVal("rst_memReq", 32'(memReq), 32'd0);
    checkVal("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // 1: plain ALU op
    aluResultIn = 32'h1234; dstRegMuxSelIn = 2'd0; wrRegIn = 1'b1; regWriteNoIn = 4'd5;
    #1;
    checkVal("alu_memReq", 32'(memReq), 32'd0);
    checkVal("alu_stall", 32'(stall), 32'd0);
    tick();
    checkVal("alu_wbData", wbData, 32'h1234);
    checkVal("alu_wbRegNo", 32'(wbRegNo), 32'd5);
    checkVal("alu_wbWrReg", 32'(wbWrReg), 32'd1);

    // 2: zero-wait load
    dstRegMuxSelIn = 2'd1; aluResultIn = 32'h40; regWriteNoIn = 4'd7; wrRegIn = 1'b1;
    memAck = 1'b1; memRdata = 32'hDEADBEEF;
    #1;
    checkVal("ld0_memReq", 32'(memReq), 32'd1);
    checkVal("ld0_memWe", 32'(memWe), 32'd0);
    checkVal("ld0_memAddr", memAddr, 32'h40);
    checkVal("ld0_stall", 32'(stall), 32'd0);
    tick();
    checkVal("ld0_wbData", wbData, 32'hDEADBEEF);
    checkVal("ld0_wbRegNo", 32'(wbRegNo), 32'd7);
    checkVal("ld0_wbWrReg", 32'(wbWrReg), 32'd1);

    // 3: store answered on its fourth cycle; inputs scrambled after issue
    idleInputs();
    wrMemIn = 1'b1; aluResultIn = 32'h80; regData2In = 32'hA5A5A5A5; regWriteNoIn = 4'd3;
    stallCount = 0;
    for (int c = 1; c <= 4; c++) begin
      memAck = (c == 4);
      #1;
      if (stall) stallCount++;
      checkVal($sformatf("st_stall_c%0d", c), 32'(stall), (c < 4) ? 32'd1 : 32'd0);
      checkVal($sformatf("st_memReq_c%0d", c), 32'(memReq), 32'd1);
      checkVal($sformatf("st_memAddr_c%0d", c), memAddr, 32'h80);
      checkVal($sformatf("st_memWdata_c%0d", c), memWdata, 32'hA5A5A5A5);
      checkVal($sformatf("st_memWe_c%0d", c), 32'(memWe), 32'd1);
      tick();
      checkVal($sformatf("st_wbWrReg_c%0d", c), 32'(wbWrReg), 32'd0);
      if (c == 1) begin
        aluResultIn = 32'h1111;
        regData2In  = 32'h0;
      end
    end
    checkVal("st_stallCount", 32'(stallCount), 32'd3);
    idleInputs();
    #1;
    checkVal("st_idle_memReq", 32'(memReq), 32'd0);

    // 4: load with no ack times out after 15 stall cycles
    dstRegMuxSelIn = 2'd1; aluResultIn = 32'h200; wrRegIn = 1'b1; regWriteNoIn = 4'd3;
    stallCount = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) break;
      stallCount++;
      tick();
    end
    checkVal("to_stallCount", 32'(stallCount), 32'd15);
    checkVal("to_memReq_last", 32'(memReq), 32'd1);
    checkVal("to_memErr_pre", 32'(memErr), 32'd0);
    tick();
    checkVal("to_memErr", 32'(memErr), 32'd1);
    checkVal("to_wbWrReg", 32'(wbWrReg), 32'd0);
    checkVal("to_wbData", wbData, 32'd0);
    idleInputs();
    memAck = 1'b1; memRdata = 32'hBAD0BAD0;
    aluResultIn = 32'h55; wrRegIn = 1'b1; regWriteNoIn = 4'd9;
    #1;
    checkVal("late_memReq", 32'(memReq), 32'd0);
    checkVal("late_stall", 32'(stall), 32'd0);
    tick();
    checkVal("late_wbData", wbData, 32'h55);
    checkVal("late_wbWrReg", 32'(wbWrReg), 32'd1);
    checkVal("late_memErr", 32'(memErr), 32'd1);

    // 5: reset during the second wait cycle of a load
    idleInputs();
    dstRegMuxSelIn = 2'd1; aluResultIn = 32'h300; wrRegIn = 1'b1; regWriteNoIn = 4'd6;
    tick();
    tick();
    reset = 1'b1;
    idleInputs();
    #1;
    checkVal("rw_memReq_pre", 32'(memReq), 32'd1);
    checkVal("rw_stall_pre", 32'(stall), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    checkVal("rw_memReq", 32'(memReq), 32'd0);
    checkVal("rw_stall", 32'(stall), 32'd0);
    checkVal("rw_wbData", wbData, 32'd0);
    checkVal("rw_wbRegNo", 32'(wbRegNo), 32'd0);
    checkVal("rw_wbWrReg", 32'(wbWrReg), 32'd0);
    checkVal("rw_memErr", 32'(memErr), 32'd0);

    // 6: PC+4 then COND select back to back
    dstRegMuxSelIn = 2'd2; pcIncrementedIn = 32'h104; wrRegIn = 1'b1; regWriteNoIn = 4'd2;
    #1;
    checkVal("pc_stall", 32'(stall), 32'd0);
    tick();
    checkVal("pc_wbData", wbData, 32'h104);
    dstRegMuxSelIn = 2'd3; condRegResultIn = 32'd1; regWriteNoIn = 4'd4;
    #1;
    checkVal("cond_stall", 32'(stall), 32'd0);
    tick();
    checkVal("cond_wbData", wbData, 32'd1);
    checkVal("cond_wbRegNo", 32'(wbRegNo), 32'd4);
    checkVal("cond_wbWrReg", 32'(wbWrReg), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
